// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings and types for the instruction-fetch stage
package fetch_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNCT_NOP = 6'b000001;
  localparam logic [31:0] NOP_WORD = {OP_SPECIAL, 20'b0, FUNCT_NOP};
  localparam int WAIT_W = 5;
  typedef enum logic [1:0] {FILL, RUN, WAIT, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_stall_counter.sv
// fetch_stall_counter: down-counter of remaining stall cycles; clk, rstn, load/load_val, en, done
module fetch_stall_counter
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              en,
  output logic              done
);
  logic [WAIT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rstn) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en) cnt <= cnt - 1'b1;
  assign done = en && cnt == WAIT_W'(1);
endmodule

// File: rtl/fetch.sv
// fetch: PC owner and BRAM addresser; clk, rstn, imem_addr/imem_rdata, dec_* controls, f_pc/f_inst/f_valid/f_bubble, halted
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_ADDR_W = 15,
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rstn,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic [31:0]            dec_npc,
  input  logic                   dec_hazard,
  input  logic                   dec_stop,
  input  logic [WAIT_W-1:0]      dec_wait_time,
  input  logic                   ext_stall,
  output logic [31:0]            f_pc,
  output logic [31:0]            f_inst,
  output logic                   f_valid,
  output logic                   f_bubble,
  output logic                   halted
);
  fetch_state_t state, nxt;
  logic [31:0] pc_reg;
  logic run, adv, load, done;
  assign run = state == RUN;
  assign adv = run && !ext_stall && !dec_stop && !dec_hazard;
  assign load = adv && dec_wait_time != '0;
  fetch_stall_counter u_cnt (
    .clk(clk),
    .rstn(rstn),
    .load(load),
    .load_val(dec_wait_time),
    .en(state == WAIT && !ext_stall),
    .done(done)
  );
  always_comb
    nxt = (state == FILL && !ext_stall) ? RUN :
          (run && !ext_stall && dec_stop) ? HALT :
          load ? WAIT :
          done ? RUN : state;
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= FILL;
      pc_reg <= RESET_PC;
    end else begin
      state <= nxt;
      if (adv) pc_reg <= dec_npc & ~32'd3;
    end
  // Outputs are forced to their reset values while rstn is low so the very first reset cycle is clean too.
  // On advance the BRAM is addressed straight from dec_npc, giving zero-penalty redirects.
  assign imem_addr = !rstn ? RESET_PC[IMEM_ADDR_W+1:2] :
                     adv ? dec_npc[IMEM_ADDR_W+1:2] : pc_reg[IMEM_ADDR_W+1:2];
  assign f_pc = rstn ? pc_reg : RESET_PC;
  assign f_valid = rstn && run;
  assign f_inst = f_valid ? imem_rdata : NOP_INST;
  assign f_bubble = rstn && (state == HALT || (run && !ext_stall && (dec_stop || dec_hazard)));
  assign halted = rstn && state == HALT;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for the fetch stage
module tb_fetch;
  localparam logic [31:0] NOP = 32'h0000_0001;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic v;
    logic b;
    logic h;
  } exp_t;
  typedef struct {
    logic rn;
    logic [31:0] npc;
    logic hz;
    logic st;
    logic [4:0] wt;
    logic xs;
    exp_t e;
  } row_t;

  logic clk = 0;
  logic rstn;
  logic [14:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] dec_npc;
  logic dec_hazard, dec_stop, ext_stall;
  logic [4:0] dec_wait_time;
  logic [31:0] f_pc, f_inst;
  logic f_valid, f_bubble, halted;
  logic [31:0] mem [0:255];
  exp_t sb[$];
  int n_run = 0;
  int n_fail = 0;

  fetch dut (
    .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_npc(dec_npc), .dec_hazard(dec_hazard), .dec_stop(dec_stop),
    .dec_wait_time(dec_wait_time), .ext_stall(ext_stall),
    .f_pc(f_pc), .f_inst(f_inst), .f_valid(f_valid), .f_bubble(f_bubble), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

  function automatic logic [31:0] bram(input logic [31:0] a);
    return (a[9:2] == 8'd0) ? 32'h2001_0005 : (32'hA000_0000 | {24'd0, a[9:2]});
  endfunction

  function automatic row_t r(input logic rn, input logic [31:0] npc, input logic hz, st,
                             input logic [4:0] wt, input logic xs,
                             input logic [31:0] pc, inst, input logic v, b, h);
    row_t x;
    x.rn = rn; x.npc = npc; x.hz = hz; x.st = st; x.wt = wt; x.xs = xs;
    x.e = '{pc: pc, inst: inst, v: v, b: b, h: h};
    return x;
  endfunction

  task automatic drive(input row_t x);
    rstn = x.rn; dec_npc = x.npc; dec_hazard = x.hz; dec_stop = x.st;
    dec_wait_time = x.wt; ext_stall = x.xs;
    sb.push_back(x.e);
  endtask

  task automatic test_reset;
    row_t rows[$];
    exp_t e, o;
    rows.push_back(r(0, 32'h4, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0));
    rows.push_back(r(0, 32'h4, 1, 1, 3, 0, 32'h0, NOP, 0, 0, 0));
    rows.push_back(r(1, 32'h80, 0, 0, 7, 0, 32'h0, NOP, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; e = sb.pop_front(); o = {f_pc, f_inst, f_valid, f_bubble, halted}; n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got pc=%h inst=%h v=%b b=%b h=%b, want pc=%h inst=%h v=%b b=%b h=%b", i, o.pc, o.inst, o.v, o.b, o.h, e.pc, e.inst, e.v, e.b, e.h);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_advance_branch;
    row_t rows[$];
    exp_t e, o;
    rows.push_back(r(1, 32'h4, 0, 0, 0, 0, 32'h0, bram(0), 1, 0, 0));
    rows.push_back(r(1, 32'h8, 0, 0, 0, 0, 32'h4, bram(4), 1, 0, 0));
    rows.push_back(r(1, 32'hC, 0, 0, 0, 0, 32'h8, bram(8), 1, 0, 0));
    rows.push_back(r(1, 32'h41, 0, 0, 0, 0, 32'hC, bram(32'hC), 1, 0, 0));
    rows.push_back(r(1, 32'h10, 0, 0, 0, 0, 32'h40, bram(32'h40), 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; e = sb.pop_front(); o = {f_pc, f_inst, f_valid, f_bubble, halted}; n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL advance[%0d]: got pc=%h inst=%h v=%b b=%b h=%b, want pc=%h inst=%h v=%b b=%b h=%b", i, o.pc, o.inst, o.v, o.b, o.h, e.pc, e.inst, e.v, e.b, e.h);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hazard;
    row_t rows[$];
    exp_t e, o;
    rows.push_back(r(1, 32'h14, 1, 0, 3, 0, 32'h10, bram(32'h10), 1, 1, 0));
    rows.push_back(r(1, 32'h14, 0, 0, 0, 0, 32'h10, bram(32'h10), 1, 0, 0));
    rows.push_back(r(1, 32'h20, 0, 0, 0, 0, 32'h14, bram(32'h14), 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; e = sb.pop_front(); o = {f_pc, f_inst, f_valid, f_bubble, halted}; n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL hazard[%0d]: got pc=%h inst=%h v=%b b=%b h=%b, want pc=%h inst=%h v=%b b=%b h=%b", i, o.pc, o.inst, o.v, o.b, o.h, e.pc, e.inst, e.v, e.b, e.h);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wait;
    row_t rows[$];
    exp_t e, o;
    rows.push_back(r(1, 32'h24, 0, 0, 5, 0, 32'h20, bram(32'h20), 1, 0, 0));
    for (int k = 0; k < 5; k++)
      rows.push_back(r(1, 32'h100, k == 2, k == 3, 0, 0, 32'h24, NOP, 0, 0, 0));
    rows.push_back(r(1, 32'h28, 0, 0, 5, 0, 32'h24, bram(32'h24), 1, 0, 0));
    for (int k = 0; k < 7; k++)
      rows.push_back(r(1, 32'h100, 0, 0, 0, k == 2 || k == 3, 32'h28, NOP, 0, 0, 0));
    rows.push_back(r(1, 32'h2C, 0, 0, 31, 0, 32'h28, bram(32'h28), 1, 0, 0));
    for (int k = 0; k < 31; k++)
      rows.push_back(r(1, 32'h200, 0, 0, 0, 0, 32'h2C, NOP, 0, 0, 0));
    rows.push_back(r(1, 32'h100, 1, 1, 4, 1, 32'h2C, bram(32'h2C), 1, 0, 0));
    rows.push_back(r(1, 32'h30, 0, 0, 0, 0, 32'h2C, bram(32'h2C), 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; e = sb.pop_front(); o = {f_pc, f_inst, f_valid, f_bubble, halted}; n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wait[%0d]: got pc=%h inst=%h v=%b b=%b h=%b, want pc=%h inst=%h v=%b b=%b h=%b", i, o.pc, o.inst, o.v, o.b, o.h, e.pc, e.inst, e.v, e.b, e.h);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stop;
    row_t rows[$];
    exp_t e, o;
    rows.push_back(r(1, 32'h34, 0, 1, 0, 0, 32'h30, bram(32'h30), 1, 1, 0));
    rows.push_back(r(1, 32'h80, 0, 0, 3, 0, 32'h30, NOP, 0, 1, 1));
    rows.push_back(r(1, 32'h80, 1, 0, 0, 1, 32'h30, NOP, 0, 1, 1));
    rows.push_back(r(1, 32'h84, 0, 1, 0, 0, 32'h30, NOP, 0, 1, 1));
    rows.push_back(r(0, 32'h84, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0));
    rows.push_back(r(1, 32'h84, 0, 0, 0, 1, 32'h0, NOP, 0, 0, 0));
    rows.push_back(r(1, 32'h84, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0));
    rows.push_back(r(1, 32'h4, 0, 0, 0, 0, 32'h0, bram(0), 1, 0, 0));
    rows.push_back(r(1, 32'h8, 0, 0, 0, 0, 32'h4, bram(4), 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2; e = sb.pop_front(); o = {f_pc, f_inst, f_valid, f_bubble, halted}; n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stop[%0d]: got pc=%h inst=%h v=%b b=%b h=%b, want pc=%h inst=%h v=%b b=%b h=%b", i, o.pc, o.inst, o.v, o.b, o.h, e.pc, e.inst, e.v, e.b, e.h);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = bram(i * 4);
    test_reset;
    test_advance_branch;
    test_hazard;
    test_wait;
    test_stop;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage, directly upstream of decode.
- Owns the architectural PC and drives the instruction-memory BRAM address (1-cycle registered read).
- Presents {pc, inst} to decode each cycle.
- Consumes decode's next-PC, hazard, stop and wait_time to redirect, hold, stall or halt the front end.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of first instruction after reset.
- IMEM_ADDR_W, 15, word-address width of instruction BRAM.
- NOP_INST, 32'h0000_0001, bubble encoding (SPECIAL opcode, funct 1 = do-nothing).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- imem_addr  out  IMEM_ADDR_W  BRAM word address; data returns next cycle
- imem_rdata  in  32  BRAM read data
- dec_npc  in  32  next PC from decode, combinational
- dec_hazard  in  1  branch/jr operand hazard from decode
- dec_stop  in  1  halt instruction in decode
- dec_wait_time  in  5  extra stall cycles required by instruction in decode
- ext_stall  in  1  global freeze (IO/memory busy)
- f_pc  out  32  PC of instruction presented to decode
- f_inst  out  32  instruction presented to decode
- f_valid  out  1  f_inst is real (not NOP_INST)
- f_bubble  out  1  decode/execute register must load NOP this cycle
- halted  out  1  stop reached

Behaviour:
- Only clk is used; reset is synchronous, active-low.
- States: FILL, RUN, WAIT, HALT. Registers: pc_reg[31:0], cnt[4:0], state.
- While rstn=0:
  - Next state FILL; pc_reg<=RESET_PC; cnt<=0.
  - Outputs: imem_addr=RESET_PC[IMEM_ADDR_W+1:2], f_valid=0, f_inst=NOP_INST, f_pc=RESET_PC, f_bubble=0, halted=0.
- Reset asserted in any state (including mid-WAIT or HALT) aborts it and behaves identically.
- f_pc=pc_reg always.
- f_inst=imem_rdata when f_valid=1, else NOP_INST.
- FILL:
  - f_valid=0; imem_addr=pc_reg word.
  - Next RUN unconditionally, unless ext_stall=1, in which case stay in FILL.
- RUN: f_valid=1. Priority ext_stall > dec_stop > dec_hazard > advance.
  - ext_stall=1: hold all state; imem_addr=pc_reg word; f_bubble=0.
  - dec_stop=1: next HALT; pc_reg held; f_bubble=1.
  - dec_hazard=1: hold pc_reg; imem_addr=pc_reg word, so the same instruction is re-presented next cycle; f_bubble=1 for exactly this cycle. Decode's hazard clears next cycle because execute holds NOP.
  - Advance:
    - pc_reg<={dec_npc[31:2],2'b00}; imem_addr=dec_npc[IMEM_ADDR_W+1:2], combinational from dec_npc, so the new instruction appears next cycle with zero redirect penalty.
    - If dec_wait_time!=0: cnt<=dec_wait_time; next WAIT.
- WAIT:
  - f_valid=0, so decode sees NOP_INST; imem_addr=pc_reg word; f_bubble=0.
  - dec_hazard and dec_stop are ignored.
  - Each cycle with ext_stall=0: cnt<=cnt-1. When cnt==1, next RUN.
  - Net effect: exactly N NOP cycles inserted after an instruction with wait_time=N.
  - ext_stall=1 freezes cnt.
- HALT: f_valid=0; f_bubble=1; halted=1; pc_reg frozen; exit only by reset.
- Width and alignment rules:
  - dec_npc[1:0] are ignored.
  - BRAM address uses bits [IMEM_ADDR_W+1:2] only; higher PC bits wrap silently (no fault).
  - pc_reg wraps mod 2^32.
- Boundary cases:
  - dec_wait_time=0 never enters WAIT.
  - dec_wait_time=31 gives 31 NOP cycles.
  - Simultaneous dec_hazard and nonzero dec_wait_time: hazard wins; no counter load.

Decomposition:
- Shared package `constant` holds:
  - NOP_INST value (OP_SPECIAL, funct 6'b000001);
  - fetch_state_t enum {FILL, RUN, WAIT, HALT};
  - WAIT_W=5.
- One natural sub-module, `stall_counter`:
  - ports: load, load value, enable, done;
  - reset to 0; done when count==1 and enabled.

Test Plan:
- Reset release with RESET_PC=0, BRAM[0]=0x20010005: FILL 1 cycle (f_valid=0, f_inst=0x00000001), then f_pc=0, f_inst=0x20010005, f_valid=1.
- Sequential advance, dec_npc=pc+4 each cycle: f_pc sequence 0,4,8,12 on consecutive cycles; f_bubble=0 throughout.
- Taken branch: at f_pc=8, dec_npc=0x40 → next cycle f_pc=0x40, f_inst=BRAM[16], no dead cycle.
- Hazard: dec_hazard=1 for one cycle at f_pc=0x10 → f_bubble=1 that cycle; f_pc=0x10 and the same f_inst next cycle; then advances.
- Load stall: dec_wait_time=5 at f_pc=0x20, dec_npc=0x24 → 5 cycles f_valid=0, f_pc=0x24; 6th cycle f_valid=1, f_inst=BRAM[9]. Repeat with ext_stall pulsed 2 cycles mid-WAIT → 7 NOP cycles total.
- Stop: dec_stop=1 at f_pc=0x30 → halted=1 next cycle and stays, f_pc=0x30 frozen, f_bubble=1. rstn=0 for 1 cycle → FILL, f_pc=RESET_PC, halted=0.
